// File: rtl/vec_cache_wr_resp_route_buf_pkg.sv
// Shared types and defaults for the vector-cache write-response path.
//   wr_resp_pld_t      : write-response payload; txnid.master_id selects the WB master
//   WB_REQ_NUM         : number of write-back request masters
//   WR_RESP_FIFO_DEPTH : default per-master response FIFO depth
package vector_cache_pkg;

  localparam int unsigned WB_REQ_NUM         = 5;
  localparam int unsigned WR_RESP_FIFO_DEPTH = 4;
  localparam int unsigned MASTER_ID_W        = 3;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } wr_resp_t;

  typedef struct packed {
    logic [MASTER_ID_W-1:0] master_id;
    logic [7:0]             rid;
  } txnid_t;

  typedef struct packed {
    txnid_t   txnid;
    wr_resp_t resp;
  } wr_resp_pld_t;

endpackage

// File: rtl/vec_cache_wr_resp_route_buf_if.sv
// Handshake bundle between write-response sources, the router and the WB masters.
//   in_wresp_vld/rdy/pld : per-source write responses into the router
//   out_resp_vld/rdy/pld : per-master buffered responses out of the router
//   route_err_vld/cnt    : dropped out-of-range response pulse and saturating count
// Modports: master = traffic side (drives sources, consumes outputs), slave = router.
interface vec_cache_wr_resp_route_buf_if
  import vector_cache_pkg::*;
#(
  parameter int unsigned IN_NUM  = 8,
  parameter int unsigned OUT_NUM = WB_REQ_NUM
);

  logic         [IN_NUM-1:0]  in_wresp_vld;
  logic         [IN_NUM-1:0]  in_wresp_rdy;
  wr_resp_pld_t [IN_NUM-1:0]  in_wresp_pld;
  logic         [OUT_NUM-1:0] out_resp_vld;
  logic         [OUT_NUM-1:0] out_resp_rdy;
  wr_resp_pld_t [OUT_NUM-1:0] out_resp_pld;
  logic                       route_err_vld;
  logic         [15:0]        route_err_cnt;

  modport master (
    output in_wresp_vld, in_wresp_pld, out_resp_rdy,
    input  in_wresp_rdy, out_resp_vld, out_resp_pld, route_err_vld, route_err_cnt
  );

  modport slave (
    input  in_wresp_vld, in_wresp_pld, out_resp_rdy,
    output in_wresp_rdy, out_resp_vld, out_resp_pld, route_err_vld, route_err_cnt
  );

endinterface

// File: rtl/vec_cache_wr_resp_rr_arb.sv
// N-request round-robin arbiter with one-hot grant.
//   clk, rst : clock, asynchronous active-high reset
//   req      : request vector
//   accept   : the current grant was consumed; pointer moves past the winner
//   gnt      : one-hot grant (zero when no request)
//   gnt_idx  : binary index of the granted request
module vec_cache_wr_resp_rr_arb #(
  parameter  int unsigned N     = 8,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             accept,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr;

  // Search starts at ptr and wraps, so the last winner has lowest priority.
  always_comb begin
    int unsigned idx;
    logic        found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!found && req[IDX_W'(idx)]) begin
        found                = 1'b1;
        gnt[IDX_W'(idx)]     = 1'b1;
        gnt_idx              = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/vec_cache_wr_resp_route_buf.sv
// Buffered write-response router: IN_NUM sources -> OUT_NUM WB masters by txnid.master_id.
// Each master has a round-robin arbiter over the sources targeting it and a
// FIFO_DEPTH-entry response FIFO (registered, no bypass, no push into a full FIFO).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : vec_cache_wr_resp_route_buf_if.slave handshake bundle
// Optional macro VEC_CACHE_WR_RESP_ROUTE_CHK_EN: out-of-range master_id is accepted,
// dropped and counted on route_err_vld/route_err_cnt; otherwise both are tied to 0.
module vec_cache_wr_resp_route_buf
  import vector_cache_pkg::*;
#(
  parameter int unsigned IN_NUM     = 8,
  parameter int unsigned OUT_NUM    = WB_REQ_NUM,
  parameter int unsigned FIFO_DEPTH = WR_RESP_FIFO_DEPTH
) (
  input logic                          clk,
  input logic                          rst,
  vec_cache_wr_resp_route_buf_if.slave bus
);

  localparam int unsigned IDX_W = (IN_NUM > 1) ? $clog2(IN_NUM) : 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);

  logic [IN_NUM-1:0] legal;
  logic [IN_NUM-1:0] acc_gnt [OUT_NUM];

`ifdef VEC_CACHE_WR_RESP_ROUTE_CHK_EN
  logic [IN_NUM-1:0] ill_acc;
  logic [15:0]       err_cnt;
  logic [15:0]       err_cnt_nxt;

  always_comb begin
    for (int unsigned i = 0; i < IN_NUM; i++) begin
      legal[i] = (32'(bus.in_wresp_pld[i].txnid.master_id) < OUT_NUM);
    end
  end

  assign ill_acc = bus.in_wresp_vld & ~legal & {IN_NUM{~rst}};

  always_comb begin
    int unsigned sum;
    sum = 32'(err_cnt);
    for (int unsigned i = 0; i < IN_NUM; i++) begin
      sum = sum + 32'(ill_acc[i]);
    end
    err_cnt_nxt = (sum > 32'hFFFF) ? 16'hFFFF : sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt <= '0;
    else     err_cnt <= err_cnt_nxt;
  end

  assign bus.route_err_vld = |ill_acc;
  assign bus.route_err_cnt = err_cnt;
`else
  assign legal             = '1;
  assign bus.route_err_vld = 1'b0;
  assign bus.route_err_cnt = '0;
`endif

  always_comb begin
    logic [IN_NUM-1:0] rdy;
    rdy = '0;
    for (int unsigned o = 0; o < OUT_NUM; o++) begin
      rdy = rdy | acc_gnt[o];
    end
`ifdef VEC_CACHE_WR_RESP_ROUTE_CHK_EN
    rdy = rdy | ill_acc;
`endif
    bus.in_wresp_rdy = rdy;
  end

  for (genvar o = 0; o < OUT_NUM; o++) begin : g_out
    logic [IN_NUM-1:0] req;
    logic [IN_NUM-1:0] gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              full;
    logic              push;
    logic              pop;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    wr_resp_pld_t      mem [FIFO_DEPTH];

    always_comb begin
      for (int unsigned i = 0; i < IN_NUM; i++) begin
        req[i] = bus.in_wresp_vld[i] & legal[i] &
                 (32'(bus.in_wresp_pld[i].txnid.master_id) == 32'(o));
      end
    end

    // Full is taken from the registered count, so a same-cycle pop never frees a slot.
    assign full = (32'(count) == FIFO_DEPTH);
    assign push = (|req) & ~full & ~rst;
    assign pop  = bus.out_resp_vld[o] & bus.out_resp_rdy[o];

    vec_cache_wr_resp_rr_arb #(.N(IN_NUM)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .accept  (push),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
    );

    assign acc_gnt[o] = push ? gnt : '0;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.in_wresp_pld[gnt_idx];
    end

    assign bus.out_resp_vld[o] = (count != '0);
    assign bus.out_resp_pld[o] = bus.out_resp_vld[o] ? mem[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_vec_cache_wr_resp_route_buf.sv
module tb_vec_cache_wr_resp_route_buf;
  import vector_cache_pkg::*;

  localparam int unsigned IN_NUM  = 8;
  localparam int unsigned OUT_NUM = WB_REQ_NUM;
  localparam int unsigned DEPTH   = WR_RESP_FIFO_DEPTH;
`ifdef VEC_CACHE_WR_RESP_ROUTE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vec_cache_wr_resp_route_buf_if #(.IN_NUM(IN_NUM), .OUT_NUM(OUT_NUM)) bus ();

  vec_cache_wr_resp_route_buf #(
    .IN_NUM     (IN_NUM),
    .OUT_NUM    (OUT_NUM),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  // Reference model: one queue per master, one round-robin pointer per master.
  wr_resp_pld_t mq [OUT_NUM][$];
  int unsigned  mptr [OUT_NUM];
  int unsigned  mcnt;

  logic [IN_NUM-1:0]  s_rdy;
  logic [IN_NUM-1:0]  s_acc;
  logic [OUT_NUM-1:0] s_ovld;
  wr_resp_pld_t       s_opld [OUT_NUM];
  logic               s_evld;
  logic [15:0]        s_ecnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < OUT_NUM; o++) begin
      mq[o].delete();
      mptr[o] = 0;
    end
    mcnt = 0;
  endtask

  task automatic set_in(input int unsigned i, input logic v, input int unsigned mid);
    bus.in_wresp_vld[i]                 = v;
    bus.in_wresp_pld[i].txnid.master_id = MASTER_ID_W'(mid);
    bus.in_wresp_pld[i].txnid.rid       = 8'($urandom);
    bus.in_wresp_pld[i].resp            = wr_resp_t'($urandom_range(0, 3));
  endtask

  function automatic int unsigned rand_mid();
    if (CHK && $urandom_range(0, 7) == 0) return $urandom_range(OUT_NUM, 7);
    return $urandom_range(0, OUT_NUM - 1);
  endfunction

  // Called just after a falling edge with inputs already driven; checks the cycle,
  // advances the model across the rising edge, returns at the next falling edge.
  task automatic cycle();
    logic [IN_NUM-1:0]  er;
    logic [OUT_NUM-1:0] ev;
    int                 g [OUT_NUM];
    int unsigned        ill;
    int unsigned        idx;
    #1;
    s_rdy  = bus.in_wresp_rdy;
    s_ovld = bus.out_resp_vld;
    for (int o = 0; o < OUT_NUM; o++) s_opld[o] = bus.out_resp_pld[o];
    s_evld = bus.route_err_vld;
    s_ecnt = bus.route_err_cnt;

    er  = '0;
    ill = 0;
    for (int o = 0; o < OUT_NUM; o++) begin
      ev[o] = (mq[o].size() != 0);
      g[o]  = -1;
      if (mq[o].size() < DEPTH) begin
        for (int unsigned k = 0; k < IN_NUM; k++) begin
          idx = (mptr[o] + k) % IN_NUM;
          if (g[o] < 0 && bus.in_wresp_vld[idx] &&
              int'(bus.in_wresp_pld[idx].txnid.master_id) == o) g[o] = int'(idx);
        end
      end
      if (g[o] >= 0) er[g[o]] = 1'b1;
    end
    for (int unsigned i = 0; i < IN_NUM; i++) begin
      if (CHK && bus.in_wresp_vld[i] && bus.in_wresp_pld[i].txnid.master_id >= OUT_NUM) begin
        er[i] = 1'b1;
        ill++;
      end
    end

    check("in_rdy", s_rdy, er);
    check("out_vld", s_ovld, ev);
    for (int o = 0; o < OUT_NUM; o++) begin
      if (ev[o]) check($sformatf("out_pld[%0d]", o), s_opld[o], mq[o][0]);
    end
    check("err_vld", s_evld, CHK && ill != 0);
    check("err_cnt", s_ecnt, CHK ? mcnt : 0);

    for (int o = 0; o < OUT_NUM; o++) begin
      if (ev[o] && bus.out_resp_rdy[o]) void'(mq[o].pop_front());
      if (g[o] >= 0) begin
        mq[o].push_back(bus.in_wresp_pld[g[o]]);
        mptr[o] = (g[o] + 1) % IN_NUM;
      end
    end
    mcnt  = (mcnt + ill > 32'hFFFF) ? 32'hFFFF : mcnt + ill;
    s_acc = er;

    @(negedge clk);
    // A source that was accepted offers a fresh transaction id on the next cycle.
    for (int unsigned i = 0; i < IN_NUM; i++) begin
      if (er[i]) begin
        bus.in_wresp_pld[i].txnid.rid = 8'($urandom);
        bus.in_wresp_pld[i].resp      = wr_resp_t'($urandom_range(0, 3));
      end
    end
  endtask

  initial begin
    wr_resp_pld_t p1;
    logic [7:0]   t2_exp [3];
    int unsigned  acc;
    logic [15:0]  c0;

    t2_exp = '{8'h01, 8'h02, 8'h20};
    rst              = 1'b1;
    bus.in_wresp_vld = '0;
    bus.in_wresp_pld = '0;
    bus.out_resp_rdy = '0;
    model_reset();
    set_in(0, 1'b1, 0);

    // Reset state
    @(posedge clk);
    #2;
    check("rst_out_vld", bus.out_resp_vld, '0);
    check("rst_in_rdy", bus.in_wresp_rdy, '0);
    check("rst_err_vld", bus.route_err_vld, 1'b0);
    check("rst_err_cnt", bus.route_err_cnt, 16'h0);
    for (int o = 0; o < OUT_NUM; o++) check("rst_out_pld", bus.out_resp_pld[o], '0);
    @(negedge clk);
    rst              = 1'b0;
    bus.in_wresp_vld = '0;

    // Single response, input 3 -> master 2
    bus.out_resp_rdy = '1;
    set_in(3, 1'b1, 2);
    p1 = bus.in_wresp_pld[3];
    cycle();
    check("t1_rdy3", s_rdy[3], 1'b1);
    bus.in_wresp_vld[3] = 1'b0;
    cycle();
    check("t1_vld2", s_ovld[2], 1'b1);
    check("t1_pld2", s_opld[2], p1);
    cycle();
    check("t1_empty", s_ovld[2], 1'b0);

    // Inputs 0, 1, 5 contend for master 0
    set_in(0, 1'b1, 0);
    set_in(1, 1'b1, 0);
    set_in(5, 1'b1, 0);
    for (int c = 0; c < 6; c++) begin
      cycle();
      check("t2_grant", s_rdy, t2_exp[c % 3]);
      if (c > 0) check("t2_out0_rate", s_ovld[0], 1'b1);
    end
    bus.in_wresp_vld = '0;
    cycle();
    check("t2_last", s_ovld[0], 1'b1);
    cycle();

    // Master 1 blocked, input 2 streaming fills the FIFO
    bus.out_resp_rdy[1] = 1'b0;
    set_in(2, 1'b1, 1);
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      acc += 32'(s_rdy[2]);
    end
    check("t3_accepts", acc, DEPTH);
    check("t3_blocked", s_rdy[2], 1'b0);
    bus.out_resp_rdy[1] = 1'b1;
    cycle();
    check("t3_full_no_push", s_rdy[2], 1'b0);
    check("t3_full_pop", s_ovld[1], 1'b1);
    cycle();
    check("t3_rdy_back", s_rdy[2], 1'b1);
    bus.in_wresp_vld[2] = 1'b0;
    for (int c = 0; c < 5; c++) cycle();
    check("t3_drained", s_ovld[1], 1'b0);

`ifdef VEC_CACHE_WR_RESP_ROUTE_CHK_EN
    // Out-of-range master_id on two inputs in one cycle
    set_in(4, 1'b1, OUT_NUM);
    set_in(6, 1'b1, OUT_NUM);
    c0 = bus.route_err_cnt;
    cycle();
    check("t4_rdy", {s_rdy[6], s_rdy[4]}, 2'b11);
    check("t4_err_vld", s_evld, 1'b1);
    bus.in_wresp_vld = '0;
    cycle();
    check("t4_cnt", s_ecnt, c0 + 16'd2);
    check("t4_no_out", s_ovld, '0);
    for (int unsigned i = 0; i < IN_NUM; i++) set_in(i, 1'b1, OUT_NUM);
    for (int c = 0; c < 8200; c++) cycle();
    bus.in_wresp_vld = '0;
    cycle();
    check("t4_sat", s_ecnt, 16'hFFFF);
`endif

    // Reset with three entries buffered for master 3
    bus.out_resp_rdy[3] = 1'b0;
    set_in(0, 1'b1, 3);
    for (int c = 0; c < 3; c++) cycle();
    check("t5_buffered", mq[3].size(), 3);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_vld", bus.out_resp_vld, '0);
    check("t5_rdy_in_rst", bus.in_wresp_rdy, '0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst              = 1'b0;
    bus.in_wresp_vld = '0;
    bus.out_resp_rdy = '1;
    cycle();
    check("t5_no_stale", s_ovld, '0);
    set_in(0, 1'b1, 3);
    p1 = bus.in_wresp_pld[0];
    cycle();
    bus.in_wresp_vld[0] = 1'b0;
    cycle();
    check("t5_new_pld", s_opld[3], p1);
    cycle();
    check("t5_empty", s_ovld[3], 1'b0);

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      for (int unsigned i = 0; i < IN_NUM; i++) begin
        if (s_acc[i] || !bus.in_wresp_vld[i]) begin
          if ($urandom_range(0, 2) != 0) set_in(i, 1'b1, rand_mid());
          else bus.in_wresp_vld[i] = 1'b0;
        end
      end
      bus.out_resp_rdy = OUT_NUM'($urandom | $urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_cache_wr_resp_route_buf.md
# vec_cache_wr_resp_route_buf

Parametrised, buffered successor to the write-response master decoder. Routes write responses from IN_NUM response sources to OUT_NUM write-back requesters using `txnid.master_id`. Adds valid/ready backpressure on both sides, per-output round-robin arbitration when several inputs target one output, and a per-output response FIFO. Sits between the cache write-response channels and the WB request masters.

## Interface
- IN_NUM, 8, number of write-response source channels
- OUT_NUM, WB_REQ_NUM, number of destination masters (need not be a power of two)
- FIFO_DEPTH, 4, entries per output FIFO (power of two, >= 2)
- clk  input  1  single clock; all logic is rising-edge
- rst  input  1  asynchronous, active-high reset
- in_wresp_vld  input  IN_NUM  per-source valid
- in_wresp_rdy  output  IN_NUM  per-source ready; transfer when vld & rdy
- in_wresp_pld  input  wr_resp_pld_t[IN_NUM]  response payload; destination = `txnid.master_id`
- out_resp_vld  output  OUT_NUM  per-master valid (FIFO non-empty)
- out_resp_rdy  input  OUT_NUM  per-master ready
- out_resp_pld  output  wr_resp_pld_t[OUT_NUM]  FIFO head payload
- route_err_vld  output  1  one-cycle pulse: out-of-range master_id accepted and dropped (macro only)
- route_err_cnt  output  16  saturating count of dropped responses (macro only)

## Operation
- Destination of input i: d(i) = master_id; width $clog2(OUT_NUM), zero-extended for comparison.
- Per output o: request vector = inputs with vld and d(i)==o; one grant per cycle via round-robin arbiter.
- in_wresp_rdy[i] = granted by its output's arbiter AND that output's FIFO not full. Combinational from vld; no rdy-to-vld loop.
- Full FIFO blocks all pushes, even when out_resp_rdy pops that cycle (no pass-through on full).
- Arbiter pointer per output: after an accepted push from input g, pointer = (g+1) mod IN_NUM. Otherwise it holds. No grant is issued when the FIFO is full, and the pointer does not move.
- Per-output ordering is preserved. Ordering between different inputs to the same output follows grant order.
- Pop when out_resp_vld & out_resp_rdy. Simultaneous push and pop on a non-full FIFO: count unchanged, both take effect.
- Pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1.
- Inputs are independent. One input never blocks another that targets a different output.

## Timing
- Push at cycle N gives out_resp_vld at N+1 (registered FIFO, no bypass). Minimum latency is 1 cycle.
- Throughput: 1 response per output per cycle, sustained with out_resp_rdy held high.
- out_resp_pld is stable while out_resp_vld & !out_resp_rdy.
- Reset: FIFOs empty, out_resp_vld=0, out_resp_pld=0, arbiter pointers=0, route_err_vld=0, route_err_cnt=0. Reset asserted mid-transfer discards all buffered responses immediately.
- in_wresp_rdy is 0 while rst is high.

## Configuration
- VEC_CACHE_WR_RESP_ROUTE_CHK_EN defined:
  - master_id >= OUT_NUM is detected.
  - That input gets rdy=1 unconditionally and its response is dropped.
  - route_err_vld pulses in the accept cycle; route_err_cnt increments and saturates at 0xFFFF.
  - Several illegal accepts in one cycle add their full count, saturating.
- Not defined:
  - No range compare is built.
  - Out-of-range master_id is illegal stimulus with undefined routing.
  - route_err_vld and route_err_cnt are tied to 0.

## Structure
- vector_cache_pkg holds: wr_resp_pld_t, WB_REQ_NUM, and a new WR_RESP_FIFO_DEPTH default constant.
- Sub-module vec_cache_wr_resp_rr_arb (N-request round-robin arbiter, one-hot grant, pointer update on accept) is instantiated OUT_NUM times.
- The FIFOs are inline generate blocks.

## Test plan
- Single response, input 3 → master 2 with out_resp_rdy=1: in_wresp_rdy[3]=1 at N, out_resp_vld[2]=1 at N+1 with the identical payload, FIFO empty at N+2.
- Inputs 0, 1, 5 all → master 0 for 6 cycles, out_resp_rdy=1:
  - first three grants are 0, 1, 5; the pattern repeats;
  - no input is starved;
  - master 0 receives exactly 1 response per cycle.
- Master 1 with out_resp_rdy=0 and FIFO_DEPTH=4, input 2 streaming:
  - exactly 4 accepts, then in_wresp_rdy[2]=0;
  - raising rdy drains 4 responses in order and rdy returns 1 cycle after the first pop.
- Full-FIFO corner: FIFO full, out_resp_rdy=1 and in_vld=1 in the same cycle → pop happens, no push; the push occurs in the next cycle.
- Macro on, master_id=OUT_NUM on inputs 4 and 6 in the same cycle:
  - both rdy=1, nothing reaches any output, route_err_vld=1, route_err_cnt += 2;
  - after 0xFFFF drops the count holds at 0xFFFF.
- Reset asserted with 3 entries buffered: out_resp_vld drops to 0 asynchronously. After release, new traffic is delivered with no stale entries.
